// File: rtl/piezo_note_sequencer.sv
// -----------------------------------------------------------------------------
// piezo_note_sequencer
//
// Plays a four-note melody for a piezo tone stage. Each note is held for
// NOTE_TICKS cycles. Consecutive notes are separated by GAP_TICKS silent
// cycles, and there is no gap after the last note. The melody code
// (event_code) selects which tone table the downstream tone stage uses. This
// block only presents that code together with the current note index.
//
// Parameters
//   NOTE_TICKS  cycles each note is held (1..2^24-1)
//   GAP_TICKS   silent cycles between consecutive notes (0..2^24-1, 0 = none)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high, beats stop and event_valid
//   event_valid  one-cycle request to play a melody
//   event_code   melody select, 1..6 valid, 0 and 7 ignored
//   stop         abort the current melody (no done pulse)
//   note_state   melody code for the tone stage (0 when idle)
//   note_played  note index 1..4 while sounding, 0 when silent
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse when a melody completes normally
//
// Configuration
//   PIEZO_SEQ_QUEUE_EN  when defined, a one-entry pending slot stores the
//                       latest valid event that arrives while busy. That
//                       melody then starts directly after the current one
//                       completes, with no idle cycle in between.
// -----------------------------------------------------------------------------
module piezo_note_sequencer #(
  parameter int unsigned NOTE_TICKS = 250000,
  parameter int unsigned GAP_TICKS  = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       event_valid,
  input  logic [2:0] event_code,
  input  logic       stop,
  output logic [2:0] note_state,
  output logic [2:0] note_played,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Terminal counts. The gap value is only used when GAP_TICKS > 0.
  localparam logic [23:0] C_NOTE_LAST = 24'(NOTE_TICKS - 1);
  localparam logic [23:0] C_GAP_LAST  = (GAP_TICKS == 0) ? 24'd0 : 24'(GAP_TICKS - 1);
  localparam logic [2:0]  C_LAST_NOTE = 3'd4;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic [23:0] r_cnt;
  logic [2:0]  r_note_idx;     // current note 1..4, kept through GAP
  logic [2:0]  r_note_state;
  logic [2:0]  r_note_played;
  logic        r_busy;
  logic        r_done;

  state_t      w_state_nx;
  logic [23:0] w_cnt_nx;
  logic [2:0]  w_note_idx_nx;
  logic [2:0]  w_note_state_nx;
  logic [2:0]  w_note_played_nx;
  logic        w_done_nx;

  logic        w_evt_ok;
  logic        w_cnt_note_end;
  logic        w_cnt_gap_end;

  assign w_evt_ok       = event_valid && (event_code != 3'd0) && (event_code != 3'd7);
  assign w_cnt_note_end = (r_cnt == C_NOTE_LAST);
  assign w_cnt_gap_end  = (r_cnt == C_GAP_LAST);

`ifdef PIEZO_SEQ_QUEUE_EN
  logic       r_pend_valid;
  logic [2:0] r_pend_code;
  logic       w_pend_valid_nx;
  logic [2:0] w_pend_code_nx;
  logic       w_chain_valid;
  logic [2:0] w_chain_code;

  // An event arriving on the final note-4 cycle has not reached the slot yet.
  // It is chained directly and overrides any older pending code (latest wins).
  assign w_chain_valid = w_evt_ok || r_pend_valid;
  assign w_chain_code  = w_evt_ok ? event_code : r_pend_code;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch. This keeps the
    // block purely combinational and prevents latch inference.
    w_state_nx       = r_state;
    w_cnt_nx         = r_cnt;
    w_note_idx_nx    = r_note_idx;
    w_note_state_nx  = r_note_state;
    w_note_played_nx = r_note_played;
    w_done_nx        = 1'b0;
`ifdef PIEZO_SEQ_QUEUE_EN
    w_pend_valid_nx  = r_pend_valid;
    w_pend_code_nx   = r_pend_code;
`endif

    if (stop) begin
      // stop wins over everything except rst, and an event in the same
      // cycle is dropped.
      w_state_nx       = S_IDLE;
      w_cnt_nx         = 24'd0;
      w_note_idx_nx    = 3'd0;
      w_note_state_nx  = 3'd0;
      w_note_played_nx = 3'd0;
`ifdef PIEZO_SEQ_QUEUE_EN
      w_pend_valid_nx  = 1'b0;
      w_pend_code_nx   = 3'd0;
`endif
    end else begin
`ifdef PIEZO_SEQ_QUEUE_EN
      // Capture while busy. The chain path below consumes the slot at the
      // end of the melody.
      if ((r_state != S_IDLE) && w_evt_ok) begin
        w_pend_valid_nx = 1'b1;
        w_pend_code_nx  = event_code;
      end
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_evt_ok) begin
            w_state_nx       = S_NOTE;
            w_cnt_nx         = 24'd0;
            w_note_idx_nx    = 3'd1;
            w_note_state_nx  = event_code;
            w_note_played_nx = 3'd1;
          end
        end

        S_NOTE: begin
          if (w_cnt_note_end) begin
            w_cnt_nx = 24'd0;
            if (r_note_idx == C_LAST_NOTE) begin
              // Normal completion. done lands in the first cycle after note 4.
              w_done_nx        = 1'b1;
              w_state_nx       = S_IDLE;
              w_note_idx_nx    = 3'd0;
              w_note_state_nx  = 3'd0;
              w_note_played_nx = 3'd0;
`ifdef PIEZO_SEQ_QUEUE_EN
              if (w_chain_valid) begin
                w_state_nx       = S_NOTE;
                w_note_idx_nx    = 3'd1;
                w_note_state_nx  = w_chain_code;
                w_note_played_nx = 3'd1;
                w_pend_valid_nx  = 1'b0;
                w_pend_code_nx   = 3'd0;
              end
`endif
            end else if (GAP_TICKS != 0) begin
              w_state_nx       = S_GAP;
              w_note_played_nx = 3'd0;
            end else begin
              w_note_idx_nx    = r_note_idx + 3'd1;
              w_note_played_nx = r_note_idx + 3'd1;
            end
          end else begin
            w_cnt_nx = r_cnt + 24'd1;
          end
        end

        S_GAP: begin
          // note_state is held through the gap, and only the index is silenced.
          if (w_cnt_gap_end) begin
            w_state_nx       = S_NOTE;
            w_cnt_nx         = 24'd0;
            w_note_idx_nx    = r_note_idx + 3'd1;
            w_note_played_nx = r_note_idx + 3'd1;
          end else begin
            w_cnt_nx = r_cnt + 24'd1;
          end
        end

        default: begin
          w_state_nx       = S_IDLE;
          w_cnt_nx         = 24'd0;
          w_note_idx_nx    = 3'd0;
          w_note_state_nx  = 3'd0;
          w_note_played_nx = 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge, regardless of statement order.
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 24'd0;
      r_note_idx    <= 3'd0;
      r_note_state  <= 3'd0;
      r_note_played <= 3'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_note_idx    <= w_note_idx_nx;
      r_note_state  <= w_note_state_nx;
      r_note_played <= w_note_played_nx;
      r_busy        <= (w_state_nx != S_IDLE);
      r_done        <= w_done_nx;
    end
  end

`ifdef PIEZO_SEQ_QUEUE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_code  <= 3'd0;
    end else begin
      r_pend_valid <= w_pend_valid_nx;
      r_pend_code  <= w_pend_code_nx;
    end
  end
`endif

  assign note_state  = r_note_state;
  assign note_played = r_note_played;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_piezo_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_piezo_note_sequencer
//
// Self-checking bench. Main instance: NOTE_TICKS=4, GAP_TICKS=2.
// Second instance: GAP_TICKS=0.
// Expected per-cycle outputs of the main instance are queued when stimulus is
// driven and popped once per cycle. An empty queue means "idle, all zero".
// -----------------------------------------------------------------------------
module tb_piezo_note_sequencer;

  localparam int NT = 4;
  localparam int GT = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       event_valid;
  logic [2:0] event_code;
  logic       stop;
  logic [2:0] note_state;
  logic [2:0] note_played;
  logic       busy;
  logic       done;

  logic       event_valid0;
  logic [2:0] event_code0;
  logic       stop0;
  logic [2:0] note_state0;
  logic [2:0] note_played0;
  logic       busy0;
  logic       done0;

  piezo_note_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .clk         (clk),
    .rst         (rst),
    .event_valid (event_valid),
    .event_code  (event_code),
    .stop        (stop),
    .note_state  (note_state),
    .note_played (note_played),
    .busy        (busy),
    .done        (done)
  );

  piezo_note_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .event_valid (event_valid0),
    .event_code  (event_code0),
    .stop        (stop0),
    .note_state  (note_state0),
    .note_played (note_played0),
    .busy        (busy0),
    .done        (done0)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] pl;
    logic       busy;
    logic       done;
  } out_t;

  typedef struct {
    logic [2:0] code;        // input: event_code driven with event_valid=1
    logic [2:0] exp_state;   // expected note_state while playing (0 = ignored)
    logic       exp_busy;    // expected: melody starts
  } vec_t;

  out_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got st=%0d pl=%0d busy=%0b done=%0b, expected st=%0d pl=%0d busy=%0b done=%0b",
                  name, act.st, act.pl, act.busy, act.done, exp.st, exp.pl, exp.busy, exp.done);
  endtask

  task automatic compare_main(input string name);
    out_t exp;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : out_t'(0);
    check(name, {note_state, note_played, busy, done}, exp);
  endtask

  // Expected outputs for one melody, from its first NOTE cycle on.
  task automatic push_melody(input logic [2:0] code, input logic first_done, input logic tail);
    for (int n = 1; n <= 4; n++) begin
      for (int t = 0; t < NT; t++)
        sb_q.push_back(out_t'{st: code, pl: 3'(n), busy: 1'b1,
                              done: (n == 1 && t == 0) ? first_done : 1'b0});
      if (n < 4)
        for (int g = 0; g < GT; g++)
          sb_q.push_back(out_t'{st: code, pl: 3'd0, busy: 1'b1, done: 1'b0});
    end
    if (tail) sb_q.push_back(out_t'{st: 3'd0, pl: 3'd0, busy: 1'b0, done: 1'b1});
  endtask

  // Inputs set before the call are sampled on this edge. They are then
  // cleared, and the main outputs are compared 1 ns after the edge.
  task automatic tick(input string name);
    @(posedge clk);
    #1;
    event_valid = 1'b0;
    stop        = 1'b0;
    rst         = 1'b0;
    compare_main(name);
  endtask

  task automatic tick_n(input string name, input int n);
    for (int i = 0; i < n; i++) tick(name);
  endtask

  task automatic send(input logic [2:0] code);
    event_valid = 1'b1;
    event_code  = code;
  endtask

  vec_t vecs[8];

  initial begin
    rst          = 1'b1;
    event_valid  = 1'b0;
    event_code   = 3'd0;
    stop         = 1'b0;
    event_valid0 = 1'b0;
    event_code0  = 3'd0;
    stop0        = 1'b0;

    vecs[0] = '{code: 3'd0, exp_state: 3'd0, exp_busy: 1'b0};
    vecs[1] = '{code: 3'd1, exp_state: 3'd1, exp_busy: 1'b1};
    vecs[2] = '{code: 3'd2, exp_state: 3'd2, exp_busy: 1'b1};
    vecs[3] = '{code: 3'd3, exp_state: 3'd3, exp_busy: 1'b1};
    vecs[4] = '{code: 3'd7, exp_state: 3'd0, exp_busy: 1'b0};
    vecs[5] = '{code: 3'd4, exp_state: 3'd4, exp_busy: 1'b1};
    vecs[6] = '{code: 3'd5, exp_state: 3'd5, exp_busy: 1'b1};
    vecs[7] = '{code: 3'd6, exp_state: 3'd6, exp_busy: 1'b1};

    // Reset state
    rst = 1'b1;
    tick("reset0");
    rst = 1'b1;
    tick("reset1");
    tick_n("idle_after_reset", 2);

    // Table: one event per row, then the full melody or idle.
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].code);
      if (vecs[v].exp_busy) push_melody(vecs[v].exp_state, 1'b0, 1'b1);
      tick($sformatf("vec%0d_code%0d", v, vecs[v].code));
      tick_n($sformatf("vec%0d_code%0d", v, vecs[v].code), 24);
    end

    // Stop at cycle 10 of a code-5 melody: silence, no done.
    send(3'd5);
    push_melody(3'd5, 1'b0, 1'b1);
    tick("stop_run");
    tick_n("stop_run", 9);
    sb_q.delete();
    stop = 1'b1;
    tick("stop_abort");
    tick_n("stop_no_done", 20);

    // Stop together with an event in IDLE: stays idle.
    send(3'd3);
    stop = 1'b1;
    tick("stop_vs_event");
    tick_n("stop_vs_event_idle", 3);

    // Reset during the first GAP of a code-3 melody, then a clean code-4 melody.
    send(3'd3);
    push_melody(3'd3, 1'b0, 1'b1);
    tick("rst_run");
    tick_n("rst_run", 4);
    sb_q.delete();
    rst = 1'b1;
    tick("rst_mid");
    tick_n("rst_idle", 2);
    send(3'd4);
    push_melody(3'd4, 1'b0, 1'b1);
    tick("after_rst");
    tick_n("after_rst", 24);

    // Events while busy: code 2 mid-melody, code 6 on the final note-4 cycle.
    send(3'd1);
`ifdef PIEZO_SEQ_QUEUE_EN
    push_melody(3'd1, 1'b0, 1'b0);
    push_melody(3'd6, 1'b1, 1'b1);
`else
    push_melody(3'd1, 1'b0, 1'b1);
`endif
    tick("busy_ev");
    tick_n("busy_ev", 4);
    send(3'd2);
    tick("busy_ev_code2");
    tick_n("busy_ev", 16);
    send(3'd6);
    tick("busy_ev_final");
`ifdef PIEZO_SEQ_QUEUE_EN
    tick_n("busy_chain", 23);
`endif
    tick_n("busy_ev_idle", 4);

    // GAP_TICKS=0 instance: 16 busy cycles, indices 1..4 back-to-back.
    event_valid0 = 1'b1;
    event_code0  = 3'd2;
    for (int c = 0; c < 18; c++) begin
      out_t exp0;
      @(posedge clk);
      #1;
      event_valid0 = 1'b0;
      if (c < 16)       exp0 = out_t'{st: 3'd2, pl: 3'(c / 4 + 1), busy: 1'b1, done: 1'b0};
      else if (c == 16) exp0 = out_t'{st: 3'd0, pl: 3'd0, busy: 1'b0, done: 1'b1};
      else              exp0 = out_t'(0);
      check($sformatf("gap0_c%0d", c), {note_state0, note_played0, busy0, done0}, exp0);
      compare_main("gap0_main_idle");
    end

    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d expected entries left, required 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
